// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch stage.
// Takes a PC from the core and issues one read on an address/read channel
// bus. It returns the word, or an error, to the core over a valid/ready handshake.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   pc, pc_valid, pc_ready        fetch request from core (pc_ready = IDLE)
//   inst, inst_valid, inst_ready  fetched word back to core
//   fetch_err, err_cause          0 none, 1 misaligned, 2 bus error, 3 timeout
//   mem_araddr/arvalid/arready    read address channel
//   mem_rdata/rresp/rvalid/rready read data channel
module ifu_fetch #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              fetch_err,
  output logic [1:0]        err_cause,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rvalid,
  output logic              mem_rready
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_ALIGN = 2'd1;
  localparam logic [1:0] CAUSE_BUS   = 2'd2;
  localparam logic [1:0] CAUSE_TMO   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_inst;
  logic              r_err;
  logic [1:0]        r_cause;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_inst_valid;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] w_inst_nxt;
  logic              w_err_nxt;
  logic [1:0]        w_cause_nxt;
  logic              w_timeout;

  // State and payload registers; bus/handshake strobes follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_inst       <= '0;
      r_err        <= 1'b0;
      r_cause      <= CAUSE_NONE;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_inst       <= w_inst_nxt;
      r_err        <= w_err_nxt;
      r_cause      <= w_cause_nxt;
      r_arvalid    <= (w_state_nxt == S_ADDR);
      r_rready     <= (w_state_nxt == S_DATA);
      r_inst_valid <= (w_state_nxt == S_HOLD);
    end
  end

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

  // Next-state and payload update.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_inst_nxt  = r_inst;
    w_err_nxt   = r_err;
    w_cause_nxt = r_cause;

    case (r_state)
      S_IDLE: begin
        if (pc_valid) begin
          w_addr_nxt = pc;
          w_cnt_nxt  = '0;
          if (pc[1:0] != 2'b00) begin
            w_state_nxt = S_HOLD;
            w_inst_nxt  = '0;
            w_err_nxt   = 1'b1;
            w_cause_nxt = CAUSE_ALIGN;
          end else begin
            w_state_nxt = S_ADDR;
          end
        end
      end

      S_ADDR: begin
        // Counter saturates at TIMEOUT so a late handshake cannot let it wrap.
        if (!w_timeout) w_cnt_nxt = r_cnt + CNT_W'(1);
        if (mem_arready) begin
          w_state_nxt = S_DATA;
        end else if (w_timeout) begin
          w_state_nxt = S_HOLD;
          w_inst_nxt  = '0;
          w_err_nxt   = 1'b1;
          w_cause_nxt = CAUSE_TMO;
        end
      end

      S_DATA: begin
        if (!w_timeout) w_cnt_nxt = r_cnt + CNT_W'(1);
        if (mem_rvalid) begin
          w_state_nxt = S_HOLD;
          if (mem_rresp != 2'b00) begin
            w_inst_nxt  = '0;
            w_err_nxt   = 1'b1;
            w_cause_nxt = CAUSE_BUS;
          end else begin
            w_inst_nxt  = mem_rdata;
            w_err_nxt   = 1'b0;
            w_cause_nxt = CAUSE_NONE;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_HOLD;
          w_inst_nxt  = '0;
          w_err_nxt   = 1'b1;
          w_cause_nxt = CAUSE_TMO;
        end
      end

      S_HOLD: begin
        if (inst_ready) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign pc_ready    = (r_state == S_IDLE);
  assign inst        = r_inst;
  assign inst_valid  = r_inst_valid;
  assign fetch_err   = r_err;
  assign err_cause   = r_cause;
  assign mem_araddr  = r_addr;
  assign mem_arvalid = r_arvalid;
  assign mem_rready  = r_rready;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: per-cycle vector table for basic fetches plus directed
// sequences for stalls, timeout, core backpressure and reset mid-fetch.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_valid;
  logic        inst_ready;
  logic        mem_arready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rvalid;

  logic        pc_ready, inst_valid, fetch_err, mem_arvalid, mem_rready;
  logic [31:0] inst, mem_araddr;
  logic [1:0]  err_cause;

  logic        t_pc_ready, t_inst_valid, t_fetch_err, t_mem_arvalid, t_mem_rready;
  logic [31:0] t_inst, t_mem_araddr;
  logic [1:0]  t_err_cause;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .fetch_err(fetch_err), .err_cause(err_cause),
    .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid),
    .mem_rready(mem_rready)
  );

  ifu_fetch #(.TIMEOUT(4)) dut_t (
    .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .pc_ready(t_pc_ready),
    .inst(t_inst), .inst_valid(t_inst_valid), .inst_ready(inst_ready),
    .fetch_err(t_fetch_err), .err_cause(t_err_cause),
    .mem_araddr(t_mem_araddr), .mem_arvalid(t_mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid),
    .mem_rready(t_mem_rready)
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        pcv;
    logic        ir;
    logic        ar;
    logic        rv;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        e_pcr;
    logic        e_arv;
    logic [31:0] e_ara;
    logic        e_rrdy;
    logic        e_iv;
    logic        e_chk;   // compare inst/fetch_err/err_cause on this row
    logic [31:0] e_inst;
    logic        e_err;
    logic [1:0]  e_cause;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc = '0; pc_valid = 1'b0; inst_ready = 1'b0; mem_arready = 1'b0;
    mem_rdata = '0; mem_rresp = 2'd0; mem_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    //         rst pc            pcv ir  ar  rv  rd            rr   | pcr arv ara           rrdy iv chk inst          err cause
    vecs[0]  = '{1'b1, 32'h0,        1'b0,1'b0,1'b0,1'b0, 32'h0,        2'd0, 1'b1,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h0,        1'b0,2'd0};
    vecs[1]  = '{1'b0, 32'h80000000, 1'b1,1'b0,1'b0,1'b0, 32'h0,        2'd0, 1'b0,1'b1,32'h80000000, 1'b0,1'b0,1'b1,32'h0,        1'b0,2'd0};
    vecs[2]  = '{1'b0, 32'h80000000, 1'b0,1'b0,1'b1,1'b0, 32'h0,        2'd0, 1'b0,1'b0,32'h0,        1'b1,1'b0,1'b1,32'h0,        1'b0,2'd0};
    vecs[3]  = '{1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b1, 32'h00100093, 2'd0, 1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h00100093, 1'b0,2'd0};
    vecs[4]  = '{1'b0, 32'h0,        1'b0,1'b1,1'b0,1'b0, 32'h0,        2'd0, 1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,2'd0};
    vecs[5]  = '{1'b0, 32'h80000002, 1'b1,1'b0,1'b0,1'b0, 32'h0,        2'd0, 1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h0,        1'b1,2'd1};
    vecs[6]  = '{1'b0, 32'h0,        1'b0,1'b0,1'b1,1'b1, 32'hCAFEF00D, 2'd0, 1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h0,        1'b1,2'd1};
    vecs[7]  = '{1'b0, 32'h0,        1'b0,1'b1,1'b0,1'b0, 32'h0,        2'd0, 1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,2'd0};
    vecs[8]  = '{1'b0, 32'h00001000, 1'b1,1'b0,1'b0,1'b0, 32'h0,        2'd0, 1'b0,1'b1,32'h00001000, 1'b0,1'b0,1'b0,32'h0,        1'b0,2'd0};
    vecs[9]  = '{1'b0, 32'h0,        1'b0,1'b0,1'b1,1'b0, 32'h0,        2'd0, 1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,2'd0};
    vecs[10] = '{1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b1, 32'hDEADBEEF, 2'd2, 1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h0,        1'b1,2'd2};
    vecs[11] = '{1'b0, 32'h0,        1'b0,1'b1,1'b0,1'b0, 32'h0,        2'd0, 1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,2'd0};
    vecs[12] = '{1'b0, 32'h00000004, 1'b1,1'b0,1'b1,1'b1, 32'hBAD0BAD0, 2'd0, 1'b0,1'b1,32'h00000004, 1'b0,1'b0,1'b0,32'h0,        1'b0,2'd0};
    vecs[13] = '{1'b0, 32'h0,        1'b0,1'b0,1'b1,1'b1, 32'hBAD0BAD0, 2'd0, 1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,2'd0};
    vecs[14] = '{1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b1, 32'h12345678, 2'd0, 1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h12345678, 1'b0,2'd0};
    vecs[15] = '{1'b0, 32'h0,        1'b0,1'b1,1'b0,1'b0, 32'h0,        2'd0, 1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,2'd0};

    // Table: one row per clock, outputs compared just after the edge.
    for (int i = 0; i < 16; i++) begin
      reset       = vecs[i].rst;
      pc          = vecs[i].pc;
      pc_valid    = vecs[i].pcv;
      inst_ready  = vecs[i].ir;
      mem_arready = vecs[i].ar;
      mem_rvalid  = vecs[i].rv;
      mem_rdata   = vecs[i].rd;
      mem_rresp   = vecs[i].rr;
      step();
      check($sformatf("v%0d.pc_ready", i),    32'(pc_ready),    32'(vecs[i].e_pcr));
      check($sformatf("v%0d.arvalid", i),     32'(mem_arvalid), 32'(vecs[i].e_arv));
      if (vecs[i].e_arv)
        check($sformatf("v%0d.araddr", i),    mem_araddr,       vecs[i].e_ara);
      check($sformatf("v%0d.rready", i),      32'(mem_rready),  32'(vecs[i].e_rrdy));
      check($sformatf("v%0d.inst_valid", i),  32'(inst_valid),  32'(vecs[i].e_iv));
      if (vecs[i].e_chk) begin
        check($sformatf("v%0d.inst", i),      inst,             vecs[i].e_inst);
        check($sformatf("v%0d.fetch_err", i), 32'(fetch_err),   32'(vecs[i].e_err));
        check($sformatf("v%0d.err_cause", i), 32'(err_cause),   32'(vecs[i].e_cause));
      end
    end

    // Memory stalls: arready low 5 cycles, rvalid low 3 cycles; inst_valid at cycle 11.
    do_reset();
    pc = 32'h80000010; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0; pc = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("stall.arvalid.c%0d", k), 32'(mem_arvalid), 32'd1);
      check($sformatf("stall.araddr.c%0d", k),  mem_araddr,       32'h80000010);
      mem_arready = (k == 6);
      step();
    end
    mem_arready = 1'b0;
    for (int k = 7; k <= 10; k++) begin
      check($sformatf("stall.rready.c%0d", k),     32'(mem_rready), 32'd1);
      check($sformatf("stall.inst_valid.c%0d", k), 32'(inst_valid), 32'd0);
      mem_rvalid = (k == 10);
      mem_rdata  = (k == 10) ? 32'h00A00513 : 32'h0;
      step();
    end
    mem_rvalid = 1'b0;
    check("stall.inst_valid.c11", 32'(inst_valid), 32'd1);
    check("stall.inst",           inst,            32'h00A00513);
    check("stall.fetch_err",      32'(fetch_err),  32'd0);

    // Core backpressure: HOLD held 10 cycles, new pc_valid not accepted.
    pc = 32'h00002000; pc_valid = 1'b1; inst_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("hold.inst_valid.%0d", k), 32'(inst_valid),  32'd1);
      check($sformatf("hold.inst.%0d", k),       inst,             32'h00A00513);
      check($sformatf("hold.pc_ready.%0d", k),   32'(pc_ready),    32'd0);
      check($sformatf("hold.arvalid.%0d", k),    32'(mem_arvalid), 32'd0);
    end
    pc_valid = 1'b0; inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("hold.release.inst_valid", 32'(inst_valid), 32'd0);
    check("hold.release.pc_ready",   32'(pc_ready),   32'd1);

    // Timeout (TIMEOUT=4): 5 ADDR cycles then HOLD with cause 3.
    do_reset();
    pc = 32'h00000100; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("tmo.arvalid.c%0d", k),    32'(t_mem_arvalid), 32'd1);
      check($sformatf("tmo.inst_valid.c%0d", k), 32'(t_inst_valid),  32'd0);
      step();
    end
    check("tmo.inst_valid", 32'(t_inst_valid),  32'd1);
    check("tmo.arvalid",    32'(t_mem_arvalid), 32'd0);
    check("tmo.inst",       t_inst,             32'h0);
    check("tmo.fetch_err",  32'(t_fetch_err),   32'd1);
    check("tmo.err_cause",  32'(t_err_cause),   32'd3);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000FFFF;
    step();
    mem_rvalid = 1'b0;
    check("tmo.late.rready",    32'(t_mem_rready), 32'd0);
    check("tmo.late.inst",      t_inst,            32'h0);
    check("tmo.late.err_cause", 32'(t_err_cause),  32'd3);

    // Handshakes on the TIMEOUT cycle win over the timeout.
    do_reset();
    pc = 32'h00000200; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      mem_arready = (k == 5);
      step();
    end
    mem_arready = 1'b0;
    check("race.rready",     32'(t_mem_rready), 32'd1);
    check("race.inst_valid", 32'(t_inst_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
    step();
    mem_rvalid = 1'b0;
    check("race.data.inst_valid", 32'(t_inst_valid), 32'd1);
    check("race.data.inst",       t_inst,            32'h00500093);
    check("race.data.err_cause",  32'(t_err_cause),  32'd0);

    // Reset in DATA: everything cleared next cycle, late rvalid ignored.
    do_reset();
    pc = 32'h80000020; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0; mem_arready = 1'b1;
    step();
    mem_arready = 1'b0;
    check("rst.pre.rready", 32'(mem_rready), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst.pc_ready",   32'(pc_ready),    32'd1);
    check("rst.arvalid",    32'(mem_arvalid), 32'd0);
    check("rst.araddr",     mem_araddr,       32'h0);
    check("rst.rready",     32'(mem_rready),  32'd0);
    check("rst.inst_valid", 32'(inst_valid),  32'd0);
    check("rst.inst",       inst,             32'h0);
    check("rst.fetch_err",  32'(fetch_err),   32'd0);
    check("rst.err_cause",  32'(err_cause),   32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    step();
    mem_rvalid = 1'b0;
    check("rst.late.inst_valid", 32'(inst_valid), 32'd0);
    check("rst.late.rready",     32'(mem_rready), 32'd0);
    check("rst.late.pc_ready",   32'(pc_ready),   32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
